// File: rtl/hs_pkg.sv
// Shared constants for the req/ack dataflow blocks.
// Used by the FIFO and by the producer/consumer models.
package hs_pkg;

    localparam int HS_DATA_W = 32;
    localparam int HS_CNT_W  = 32;

    function automatic int hs_ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/hs_resp_fifo_if.sv
// Handshake bundle for hs_resp_fifo: upstream req/ack, downstream
// req/ack, and the status outputs. slave is the FIFO side.
interface hs_resp_fifo_if
    import hs_pkg::*;
#(
    parameter int DW = HS_DATA_W,
    parameter int LW = 3
);
    logic                req_l;
    logic                ack_l;
    logic [DW-1:0]       din;
    logic                req_r;
    logic                ack_r;
    logic [DW-1:0]       dout;
    logic [LW-1:0]       level;
    logic [HS_CNT_W-1:0] count;

    modport master (
        input  req_l, ack_r, dout, level, count,
        output ack_l, din, req_r
    );

    modport slave (
        output req_l, ack_r, dout, level, count,
        input  ack_l, din, req_r
    );
endinterface

// File: rtl/hs_fifo_mem.sv
// depth x data_width storage, write on clk, combinational read.
// Deliberately unreset; validity is tracked by the controller.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int data_width = HS_DATA_W,
    parameter int depth      = 4,
    localparam int PW        = hs_ptr_w(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PW-1:0]         waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [PW-1:0]         raddr,
    output logic [data_width-1:0] rdata
);
    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/hs_resp_fifo.sv
// Elastic req/ack buffer: initiator upstream, responder downstream.
// `define HS_RESP_FIFO_ERR_EN adds a sticky protocol-error output err.
module hs_resp_fifo
    import hs_pkg::*;
#(
    parameter int data_width = HS_DATA_W,
    parameter int depth      = 4,
    parameter logic [data_width-1:0] initial_value = '0,
    localparam int PW        = hs_ptr_w(depth),
    localparam int LW        = PW + 1
) (
    input  logic clk,
    input  logic rst,
`ifdef HS_RESP_FIFO_ERR_EN
    output logic err,
`endif
    hs_resp_fifo_if.slave f
);
    localparam logic [LW-1:0] FULL_LVL = LW'(depth);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  req_l_q;
    logic                  ack_r_q;
    logic [data_width-1:0] dout_q;
    logic [data_width-1:0] rdata;
    logic [HS_CNT_W-1:0]   cnt_q;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  pop;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    // an ack without an outstanding request is dropped
    assign wr_en = f.ack_l & req_l_q;
    assign pop   = f.req_r & ~ack_r_q & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            req_l_q <= 1'b0;
            ack_r_q <= 1'b0;
            dout_q  <= initial_value;
            cnt_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr  <= wr_ptr + PW'(1);
                req_l_q <= 1'b0;
            end else if (~req_l_q & ~f.ack_l & ~full) begin
                req_l_q <= 1'b1;
            end
            ack_r_q <= pop;
            if (pop) begin
                dout_q <= rdata;
                rd_ptr <= rd_ptr + PW'(1);
                cnt_q  <= cnt_q + HS_CNT_W'(1);
            end
            level_q <= level_q + LW'(wr_en) - LW'(pop);
        end
    end

`ifdef HS_RESP_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (f.ack_l & (~req_l_q | full)) begin
            err <= 1'b1;
        end
    end
`endif

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (f.din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign f.req_l = req_l_q;
    assign f.ack_r = ack_r_q;
    assign f.dout  = dout_q;
    assign f.level = level_q;
    assign f.count = cnt_q;
endmodule

// File: tb/tb_hs_resp_fifo.sv
// Directed bench for hs_resp_fifo (depth 4, 32-bit).
// Build with HS_RESP_FIFO_ERR_EN to also check the err output.
module tb_hs_resp_fifo;
    import hs_pkg::*;

    localparam int N = 5000;
    localparam int LIM = 30000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    hs_resp_fifo_if #(.DW(32), .LW(3)) f ();

`ifdef HS_RESP_FIFO_ERR_EN
    logic err;
`endif

    hs_resp_fifo dut (
        .clk (clk),
        .rst (rst),
`ifdef HS_RESP_FIFO_ERR_EN
        .err (err),
`endif
        .f   (f.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        int n;
        n = 0;
        while (!f.req_l && n < 20) begin
            step();
            n++;
        end
        chk("push_req_l", 64'(f.req_l), 1);
        f.ack_l = 1'b1;
        f.din   = 32'(v);
        step();
        f.ack_l = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input int v);
        int n;
        n = 0;
        step();
        while (!f.ack_r && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ack"}, 64'(f.ack_r), 1);
        chk(tag, 64'(f.dout), 64'(v));
    endtask

    task automatic rst_pulse();
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic soak(input int fr);
        int errs;
        int got;
        errs = 0;
        got = 0;
        rst_pulse();
        fork
            begin
                int i;
                int g;
                i = 0;
                g = 0;
                while (i < N && g < LIM) begin
                    if (f.req_l && $urandom_range(99) >= fr) begin
                        f.ack_l = 1'b1;
                        f.din   = 32'(i);
                        i++;
                    end
                    step();
                    f.ack_l = 1'b0;
                    g++;
                end
            end
            begin
                int g;
                g = 0;
                while (got < N && g < LIM) begin
                    f.req_r = ($urandom_range(99) >= fr);
                    step();
                    g++;
                    if (f.ack_r) begin
                        if (f.dout !== 32'(got)) errs++;
                        got++;
                    end
                end
                f.req_r = 1'b0;
            end
        join
        chk("soak_order", 64'(errs), 0);
        chk("soak_words", 64'(got), N);
        chk("soak_count", 64'(f.count), N);
        chk("soak_level", 64'(f.level), 0);
    endtask

    initial begin
        int k;
        int last;
        f.ack_l = 1'b0;
        f.din   = '0;
        f.req_r = 1'b0;

        #2;
        chk("rst_req_l", 64'(f.req_l), 0);
        chk("rst_ack_r", 64'(f.ack_r), 0);
        chk("rst_dout", 64'(f.dout), 0);
        chk("rst_level", 64'(f.level), 0);
        chk("rst_count", 64'(f.count), 0);
        #10 rst = 1'b0;
        step();

        // fill with no downstream demand
        push(10);
        push(11);
        push(12);
        push(13);
        chk("fill_level", 64'(f.level), 4);
        for (int c = 0; c < 4; c++) step();
        chk("full_req_l", 64'(f.req_l), 0);
        chk("full_ack_r", 64'(f.ack_r), 0);
        chk("full_level", 64'(f.level), 4);

        // drain with req_r held
        f.req_r = 1'b1;
        k = 0;
        last = -1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            step();
            if (f.ack_r) begin
                chk("drain_dout", 64'(f.dout), 64'(10 + k));
                if (last >= 0) chk("drain_gap", 64'(c - last), 2);
                last = c;
                k++;
            end
        end
        chk("drain_n", 64'(k), 4);
        step();
        step();
        step();
        chk("empty_ack_r", 64'(f.ack_r), 0);
        chk("empty_dout", 64'(f.dout), 13);
        chk("drain_count", 64'(f.count), 4);
        chk("drain_level", 64'(f.level), 0);
        f.req_r = 1'b0;

        // simultaneous write and pop at level 2
        push(20);
        push(21);
        chk("conc_pre", 64'(f.level), 2);
        k = 0;
        while (!f.req_l && k < 20) begin
            step();
            k++;
        end
        f.ack_l = 1'b1;
        f.din   = 32'd22;
        f.req_r = 1'b1;
        step();
        f.ack_l = 1'b0;
        f.req_r = 1'b0;
        chk("conc_level", 64'(f.level), 2);
        chk("conc_ack_r", 64'(f.ack_r), 1);
        chk("conc_dout", 64'(f.dout), 20);
        f.req_r = 1'b1;
        pop_expect("conc_d21", 21);
        pop_expect("conc_d22", 22);
        f.req_r = 1'b0;
        chk("conc_count", 64'(f.count), 7);
        chk("conc_empty", 64'(f.level), 0);

        // async reset between edges in mid-drain
        push(30);
        push(31);
        push(32);
        f.req_r = 1'b1;
        pop_expect("ar_d30", 30);
        #2 rst = 1'b1;
        #1;
        chk("ar_req_l", 64'(f.req_l), 0);
        chk("ar_ack_r", 64'(f.ack_r), 0);
        chk("ar_dout", 64'(f.dout), 0);
        chk("ar_level", 64'(f.level), 0);
        chk("ar_count", 64'(f.count), 0);
        #1 rst = 1'b0;
        f.req_r = 1'b0;
        step();
        push(40);
        chk("ar_lvl1", 64'(f.level), 1);
        chk("ar_hold", 64'(f.dout), 0);
        f.req_r = 1'b1;
        pop_expect("ar_d40", 40);
        f.req_r = 1'b0;
        chk("ar_cnt1", 64'(f.count), 1);

        // ack_l with no outstanding request is dropped
        rst_pulse();
        f.ack_l = 1'b1;
        f.din   = 32'd99;
        step();
        f.ack_l = 1'b0;
        chk("viol_level", 64'(f.level), 0);
        chk("viol_req_l", 64'(f.req_l), 0);
`ifdef HS_RESP_FIFO_ERR_EN
        chk("viol_err", 64'(err), 1);
`endif
        push(51);
        f.req_r = 1'b1;
        pop_expect("viol_d51", 51);
        f.req_r = 1'b0;
        step();
        chk("viol_cnt", 64'(f.count), 1);
        chk("viol_lvl2", 64'(f.level), 0);
`ifdef HS_RESP_FIFO_ERR_EN
        chk("viol_sticky", 64'(err), 1);
        rst_pulse();
        chk("err_rst", 64'(err), 0);
`endif

        soak(0);
        soak(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
